// File: rtl/if_fetch_queue_pkg.sv
// Shared bus-width and PC-step constants for the instruction fetch path.
package if_fetch_queue_pkg;
    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam int PcIncr      = 4;
endpackage

// File: rtl/if_fetch_queue_fifo_sync.sv
// Synchronous circular queue with clear; head entry shown combinationally.
module fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[tail_q] <= din;
    end

    assign count = count_q;
    assign head  = mem[head_q];
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: PC register, ROM read control and a small prefetch queue.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus,
    parameter int DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    input  logic [INST_W-1:0] rom_data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int ENT_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head;
    logic              full;
    logic              pop;
    logic              push;

    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = valid_o && ready_i && !flush_i;
    // Gated by rst so the ROM is never enabled while reset is asserted.
    assign push  = rst && fetch_en_i && !flush_i && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (flush_i) begin
            pc_q <= flush_pc_i & ~ADDR_W'(3);
        end else if (push) begin
            pc_q <= pc_q + ADDR_W'(PcIncr);
        end
    end

    fifo_sync #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clr   (flush_i),
        .din   ({pc_q, rom_data_i}),
        .count (count),
        .head  (head)
    );

    assign rom_addr_o = pc_q;
    assign rom_ce_o   = push;
    assign valid_o    = (count != '0);
    assign count_o    = count;
    assign pc_o       = head[INST_W +: ADDR_W];
    assign inst_o     = head[INST_W-1:0];
endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fetch_en_i = 1'b0;
    logic              flush_i = 1'b0;
    logic [ADDR_W-1:0] flush_pc_i = '0;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_ce_o;
    logic [INST_W-1:0] rom_data_i;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic [CNT_W-1:0]  count_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t              q[$];
    logic [ADDR_W-1:0] mpc = '0;

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] rom(input logic [ADDR_W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign rom_data_i = rom(rom_addr_o);

    if_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en_i (fetch_en_i),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .rom_addr_o (rom_addr_o),
        .rom_ce_o   (rom_ce_o),
        .rom_data_i (rom_data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .count_o    (count_o)
    );

    task automatic drive(input logic fe, input logic fl, input logic [ADDR_W-1:0] fpc,
                         input logic rdy);
        fetch_en_i = fe;
        flush_i    = fl;
        flush_pc_i = fpc;
        ready_i    = rdy;
        #1;
    endtask

    // Reference behaviour: the cycle's rules applied to an unbounded queue.
    task automatic tick();
        bit pop;
        bit ce;
        if (rst) begin
            pop = (q.size() > 0) && ready_i && !flush_i;
            ce  = fetch_en_i && !flush_i && ((q.size() < DEPTH) || pop);
            if (flush_i) begin
                q.delete();
                mpc = {flush_pc_i[ADDR_W-1:2], 2'b00};
            end else begin
                if (pop) void'(q.pop_front());
                if (ce) begin
                    q.push_back('{pc: mpc, inst: rom(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit exp_ce();
        return rst && fetch_en_i && !flush_i &&
               ((q.size() < DEPTH) || ((q.size() > 0) && ready_i));
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b0, '0, 1'b1);
        checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", rom_ce_o); end
        checks++; if (rom_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", rom_addr_o); end
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        mpc = '0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            checks++; if (rom_ce_o !== exp_ce()) begin errors++; $display("FAIL fill_ce[%0d]: got %b want %b", i, rom_ce_o, exp_ce()); end
            checks++; if (rom_addr_o !== mpc) begin errors++; $display("FAIL fill_addr[%0d]: got %h want %h", i, rom_addr_o, mpc); end
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (count_o !== CNT_W'(4)) begin errors++; $display("FAIL fill_count: got %0d want 4", count_o); end
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL fill_ce_full: got %b want 0", rom_ce_o); end
        checks++; if (rom_addr_o !== 32'h10) begin errors++; $display("FAIL fill_pc_hold: got %h want 10", rom_addr_o); end
        checks++; if (pc_o !== 32'h0 || inst_o !== rom(32'h0)) begin errors++; $display("FAIL fill_head: got %h/%h want 0/%h", pc_o, inst_o, rom(32'h0)); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, '0, 1'b1);
            checks++; if (pc_o !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, pc_o, 32'(4 * k)); end
            checks++; if (inst_o !== rom(32'(4 * k))) begin errors++; $display("FAIL stream_inst[%0d]: got %h want %h", k, inst_o, rom(32'(4 * k))); end
            checks++; if (count_o !== CNT_W'(4) || rom_ce_o !== 1'b1) begin errors++; $display("FAIL stream_full[%0d]: got cnt %0d ce %b want 4/1", k, count_o, rom_ce_o); end
            tick();
        end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        checks++; if (count_o !== CNT_W'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count_o); end
        drive(1'b1, 1'b1, 32'h103, 1'b1);
        checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL flush_ce: got %b want 0", rom_ce_o); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (count_o !== '0 || valid_o !== 1'b0) begin errors++; $display("FAIL flush_empty: got cnt %0d v %b want 0/0", count_o, valid_o); end
        checks++; if (rom_addr_o !== 32'h100) begin errors++; $display("FAIL flush_addr: got %h want 100", rom_addr_o); end
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h100) begin errors++; $display("FAIL flush_first_pc: got v %b pc %h want 1/100", valid_o, pc_o); end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (rom_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start: got %h want fffffffc", rom_addr_o); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (rom_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 0", rom_addr_o); end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pop0: got %h want fffffffc", pc_o); end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (pc_o !== 32'h0 || inst_o !== rom(32'h0)) begin errors++; $display("FAIL wrap_pop1: got %h/%h want 0/%h", pc_o, inst_o, rom(32'h0)); end
        tick();
    endtask

    task automatic test_drain();
        drive(1'b0, 1'b1, 32'h40, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            checks++; if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h48) begin errors++; $display("FAIL drain_hold[%0d]: got ce %b addr %h want 0/48", i, rom_ce_o, rom_addr_o); end
            if (i < 2) begin
                checks++; if (valid_o !== 1'b1 || pc_o !== 32'(32'h40 + 4 * i)) begin errors++; $display("FAIL drain_pc[%0d]: got v %b pc %h want 1/%h", i, valid_o, pc_o, 32'(32'h40 + 4 * i)); end
            end else begin
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", valid_o); end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 32'h200, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, '0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (count_o !== CNT_W'(2)) begin errors++; $display("FAIL arst_pre: got %0d want 2", count_o); end
        rst = 1'b0;
        #1;
        checks++; if (count_o !== '0 || valid_o !== 1'b0) begin errors++; $display("FAIL arst_clear: got cnt %0d v %b want 0/0", count_o, valid_o); end
        checks++; if (rom_addr_o !== 32'h0 || rom_ce_o !== 1'b0) begin errors++; $display("FAIL arst_addr: got %h ce %b want 0/0", rom_addr_o, rom_ce_o); end
        q.delete();
        mpc = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (rom_addr_o !== 32'h0 || rom_ce_o !== 1'b1) begin errors++; $display("FAIL arst_release: got %h ce %b want 0/1", rom_addr_o, rom_ce_o); end
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin errors++; $display("FAIL arst_first: got v %b pc %h want 1/0", valid_o, pc_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  32'($urandom), 1'($urandom_range(0, 1)));
            checks++; if (count_o !== CNT_W'(q.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count_o, q.size()); end
            checks++; if (valid_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, valid_o, q.size() != 0); end
            checks++; if (rom_ce_o !== exp_ce()) begin errors++; $display("FAIL rnd_ce[%0d]: got %b want %b", i, rom_ce_o, exp_ce()); end
            checks++; if (rom_addr_o !== mpc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, rom_addr_o, mpc); end
            if (q.size() != 0) begin
                checks++; if (pc_o !== q[0].pc || inst_o !== q[0].inst) begin errors++; $display("FAIL rnd_head[%0d]: got %h/%h want %h/%h", i, pc_o, inst_o, q[0].pc, q[0].inst); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_drain();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning instruction address width.
REQ-002 The block SHALL have parameter INST_W, default 32, meaning instruction word width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two, 2 or greater.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port fetch_en_i, input, 1 bit: permit new ROM fetches.
REQ-008 The block SHALL have port flush_i, input, 1 bit: redirect request (taken branch or jump).
REQ-009 The block SHALL have port flush_pc_i, input, ADDR_W bits: redirect target.
REQ-010 The block SHALL have port rom_addr_o, output, ADDR_W bits: ROM read address.
REQ-011 The block SHALL have port rom_ce_o, output, 1 bit: ROM read enable.
REQ-012 The block SHALL have port rom_data_i, input, INST_W bits: ROM data, combinationally valid in the same cycle as rom_addr_o.
REQ-013 The block SHALL have port valid_o, output, 1 bit: head entry available.
REQ-014 The block SHALL have port ready_i, input, 1 bit: decode stage accepts the head entry.
REQ-015 The block SHALL have port pc_o, output, ADDR_W bits: PC of the head entry.
REQ-016 The block SHALL have port inst_o, output, INST_W bits: instruction of the head entry.
REQ-017 The block SHALL have port count_o, output, clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-018 The block SHALL hold a fetch PC register and drive rom_addr_o from it combinationally.
REQ-019 The block SHALL assert rom_ce_o when fetch_en_i=1, flush_i=0, and either count<DEPTH or a pop occurs in the same cycle.
REQ-020 Each cycle with rom_ce_o=1, the block SHALL push {rom_addr_o, rom_data_i} at the tail and advance the PC by 4, wrapping modulo 2^ADDR_W.
REQ-021 A pop SHALL occur exactly when valid_o=1, ready_i=1 and flush_i=0; the head then advances by one entry.
REQ-022 valid_o SHALL equal (count_o != 0); there is no empty-queue bypass, so minimum fetch-to-valid_o latency is one cycle.
REQ-023 pc_o and inst_o SHALL show the head entry whenever valid_o=1; their value when valid_o=0 is don't-care.
REQ-024 On simultaneous push and pop, count SHALL stay unchanged, including at DEPTH (full) and at 1.
REQ-025 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-026 On flush_i=1, at the next edge count SHALL become 0 and the PC SHALL load {flush_pc_i[ADDR_W-1:2], 2'b00}; no push or pop SHALL occur in that cycle.
REQ-027 A flush SHALL take priority over any push, pop or fetch_en_i in the same cycle.
REQ-028 With fetch_en_i=0, the PC SHALL hold and the queue SHALL drain through pops only.
REQ-029 When full with no pop, rom_ce_o SHALL be 0 and the PC SHALL hold.

Reset
REQ-030 While rst=0, asynchronously: PC=RESET_PC, pointers=0, count_o=0, valid_o=0, rom_ce_o=0.
REQ-031 rom_addr_o SHALL equal RESET_PC during reset.
REQ-032 Queue storage SHALL need no reset.
REQ-033 An assertion of rst mid-operation SHALL discard all entries immediately; the first fetch after release SHALL be RESET_PC.

Structure
REQ-034 Bus-width constants (InstAddrBus, InstBus) and the PC increment of 4 SHALL come from the shared defines file.
REQ-035 Storage and pointer logic SHALL be one sub-module, fifo_sync (parameters WIDTH, DEPTH), with inputs push, pop and clr, and outputs count and head data.
REQ-036 PC and fetch control SHALL reside in if_fetch_queue.

Verification
REQ-037 Reset release, fetch_en_i=1, ready_i=0, DEPTH=4 -> four pushes at PCs 0x0, 0x4, 0x8, 0xC; count_o=4; rom_ce_o=0; PC holds at 0x10.
REQ-038 Full queue, ready_i=1 continuously -> one push and one pop per cycle; count_o stays 4; pc_o sequence 0x0, 0x4, 0x8, ...
REQ-039 Three entries queued, flush_i=1 with flush_pc_i=0x103 -> next cycle count_o=0, valid_o=0, rom_addr_o=0x100; first new pc_o=0x100.
REQ-040 ADDR_W=8, PC=0xFC, fetch_en_i=1 -> the next PC is 0x00; entries 0xFC and 0x00 pop in order.
REQ-041 rst driven to 0 mid-cycle with count_o=2 -> count_o=0 and valid_o=0 without waiting for a clock edge; after release rom_addr_o=RESET_PC.
REQ-042 fetch_en_i=0 with two entries and ready_i=1 -> two pops, then valid_o=0; rom_ce_o stays 0 and the PC is unchanged.
